// File: rtl/access_pkg.sv
// Shared types, default widths and width helper for the access controller.
package access_pkg;

   localparam int DEF_DIGIT_W     = 4;
   localparam int DEF_NUM_DIGITS  = 4;
   localparam int DEF_NUM_USERS   = 4;
   localparam int DEF_ROM_LAT     = 2;
   localparam int DEF_MAX_FAIL    = 3;
   localparam int DEF_LOCK_CYCLES = 1024;

   // Controller states; C_FETCH covers the whole ISSUE/WAIT/CAPTURE walk.
   typedef enum logic [2:0] {
      C_ENTER  = 3'd0,
      C_FETCH  = 3'd1,
      C_DECIDE = 3'd2,
      C_GRANT  = 3'd3,
      C_LOCKED = 3'd4
   } ctl_e;

   typedef enum logic [1:0] {
      F_IDLE    = 2'd0,
      F_ISSUE   = 2'd1,
      F_WAIT    = 2'd2,
      F_CAPTURE = 2'd3
   } fetch_e;

   // ceil(log2(v)), never below 1 so single-entry fields still get a bit.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/access_controller_p_if.sv
// Keypad / ROM / LED bundle between the front end (master) and the controller (slave).
interface access_controller_p_if
   import access_pkg::*;
#(
   parameter int DIGIT_W    = DEF_DIGIT_W,
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int NUM_USERS  = DEF_NUM_USERS,
   parameter int MAX_FAIL   = DEF_MAX_FAIL
) ();
   localparam int UW = clog2(NUM_USERS);
   localparam int AW = clog2(NUM_USERS * NUM_DIGITS);
   localparam int FW = clog2(MAX_FAIL + 1);

   logic [DIGIT_W-1:0] pass_inp;
   logic               load_pass_number;
   logic [UW-1:0]      user_sel;
   logic               log_out;
   logic [AW-1:0]      rom_addr;
   logic [DIGIT_W-1:0] rom_data;
   logic               gled;
   logic               rled;
   logic [DIGIT_W-1:0] pwd_disp;
   logic [FW-1:0]      fail_cnt;
   logic               locked;

   modport master (
      output pass_inp, load_pass_number, user_sel, log_out, rom_data,
      input  rom_addr, gled, rled, pwd_disp, fail_cnt, locked
   );

   modport slave (
      input  pass_inp, load_pass_number, user_sel, log_out, rom_data,
      output rom_addr, gled, rled, pwd_disp, fail_cnt, locked
   );
endinterface

// File: rtl/pwd_rom_fetch.sv
// Walks all stored digits of one user through the synchronous ROM and folds
// the per-digit compares into a single match; done/match are valid in the last CAPTURE.
module pwd_rom_fetch
   import access_pkg::*;
#(
   parameter int DIGIT_W    = DEF_DIGIT_W,
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int ROM_LAT    = DEF_ROM_LAT,
   parameter int AW         = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                clr,
   input  logic [AW-1:0]                       base,
   input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  pwd_buf,
   input  logic [DIGIT_W-1:0]                  rom_data,
   output logic [AW-1:0]                       rom_addr,
   output logic                                done,
   output logic                                match
);
   localparam int IW = clog2(NUM_DIGITS);
   localparam int LW = clog2(ROM_LAT);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(ROM_LAT - 1);

   fetch_e        fst_q, fst_d;
   logic [IW-1:0] fidx_q, fidx_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          acc_q, acc_d;
   logic [AW-1:0] addr_q, addr_d;

   assign done     = (fst_q == F_CAPTURE) && (fidx_q == LAST_IDX);
   assign match    = acc_q && (rom_data == pwd_buf[fidx_q]);
   assign rom_addr = addr_q;

   always_comb begin
      fst_d  = fst_q;
      fidx_d = fidx_q;
      lat_d  = lat_q;
      acc_d  = acc_q;
      addr_d = addr_q;
      case (fst_q)
         F_IDLE: if (start) begin
            fst_d  = F_ISSUE;
            fidx_d = '0;
            acc_d  = 1'b1;
         end
         F_ISSUE: begin
            addr_d = base + AW'(fidx_q);
            lat_d  = '0;
            fst_d  = F_WAIT;
         end
         F_WAIT: begin
            if (lat_q == LAT_LAST) fst_d = F_CAPTURE;
            else                   lat_d = lat_q + 1'b1;
         end
         F_CAPTURE: begin
            // keep fetching after a mismatch so timing never leaks the data
            acc_d = match;
            if (done) begin
               fst_d = F_IDLE;
            end else begin
               fidx_d = fidx_q + 1'b1;
               fst_d  = F_ISSUE;
            end
         end
         default: fst_d = F_IDLE;
      endcase
      if (clr) begin
         fst_d  = F_IDLE;
         addr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fst_q  <= F_IDLE;
         fidx_q <= '0;
         lat_q  <= '0;
         acc_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         fst_q  <= fst_d;
         fidx_q <= fidx_d;
         lat_q  <= lat_d;
         acc_q  <= acc_d;
         addr_q <= addr_d;
      end
   end
endmodule

// File: rtl/access_controller_p.sv
// Multi-user keypad access controller comparing entered digits against an external ROM.
// Optional consecutive-failure lockout: define ACCESS_LOCKOUT_EN.
module access_controller_p
   import access_pkg::*;
#(
   parameter int DIGIT_W     = DEF_DIGIT_W,
   parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter int NUM_USERS   = DEF_NUM_USERS,
   parameter int ROM_LAT     = DEF_ROM_LAT,
   parameter int MAX_FAIL    = DEF_MAX_FAIL,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   access_controller_p_if.slave  bus
);
   localparam int UW = clog2(NUM_USERS);
   localparam int AW = clog2(NUM_USERS * NUM_DIGITS);
   localparam int FW = clog2(MAX_FAIL + 1);
   localparam int IW = clog2(NUM_DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FAIL_SAT = FW'(MAX_FAIL);

   if (NUM_DIGITS < 1 || NUM_USERS < 1 || ROM_LAT < 1 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_param_chk
      $error("access_controller_p: parameter out of range");
   end

   ctl_e                              st_q, st_d;
   logic [IW-1:0]                     idx_q, idx_d;
   logic [UW-1:0]                     user_q, user_d;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] buf_q, buf_d;
   logic [DIGIT_W-1:0]                disp_q, disp_d;
   logic                              gled_q, gled_d;
   logic                              rled_q, rled_d;
   logic [FW-1:0]                     fail_q, fail_d;
   logic                              match_q, match_d;

   logic          st_bad, fetch_start, fetch_clr, fetch_done, fetch_match;
   logic [AW-1:0] fetch_base;
   logic [FW-1:0] fail_inc;

   assign fetch_start = (st_q == C_ENTER) && bus.load_pass_number && (idx_q == LAST_IDX);
   assign fetch_clr   = ((st_q == C_GRANT) && bus.log_out) || st_bad;
   assign fetch_base  = AW'(user_q * NUM_DIGITS);
   assign fail_inc    = (fail_q == FAIL_SAT) ? fail_q : fail_q + 1'b1;

   pwd_rom_fetch #(
      .DIGIT_W    (DIGIT_W),
      .NUM_DIGITS (NUM_DIGITS),
      .ROM_LAT    (ROM_LAT),
      .AW         (AW)
   ) u_fetch (
      .clk      (clk),
      .rst      (rst),
      .start    (fetch_start),
      .clr      (fetch_clr),
      .base     (fetch_base),
      .pwd_buf  (buf_q),
      .rom_data (bus.rom_data),
      .rom_addr (bus.rom_addr),
      .done     (fetch_done),
      .match    (fetch_match)
   );

`ifdef ACCESS_LOCKOUT_EN
   localparam int CW = clog2(LOCK_CYCLES);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
   logic          locked_q, locked_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   assign st_bad     = !(st_q inside {C_ENTER, C_FETCH, C_DECIDE, C_GRANT, C_LOCKED});
   assign bus.locked = locked_q;
`else
   assign st_bad     = !(st_q inside {C_ENTER, C_FETCH, C_DECIDE, C_GRANT});
   assign bus.locked = 1'b0;
`endif

   always_comb begin
      st_d    = st_q;
      idx_d   = idx_q;
      user_d  = user_q;
      buf_d   = buf_q;
      disp_d  = disp_q;
      gled_d  = gled_q;
      rled_d  = rled_q;
      fail_d  = fail_q;
      match_d = match_q;
`ifdef ACCESS_LOCKOUT_EN
      locked_d   = locked_q;
      lock_cnt_d = lock_cnt_q;
`endif
      case (st_q)
         C_ENTER: if (bus.load_pass_number) begin
            buf_d[idx_q] = bus.pass_inp;
            disp_d       = bus.pass_inp;
            if (idx_q == '0) user_d = bus.user_sel;
            if (idx_q == LAST_IDX) begin
               idx_d = '0;
               st_d  = C_FETCH;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         C_FETCH: if (fetch_done) begin
            match_d = fetch_match;
            st_d    = C_DECIDE;
         end
         C_DECIDE: begin
            if (match_q) begin
               gled_d = 1'b1;
               rled_d = 1'b0;
               fail_d = '0;
               st_d   = C_GRANT;
            end else begin
               fail_d = fail_inc;
               idx_d  = '0;
               st_d   = C_ENTER;
`ifdef ACCESS_LOCKOUT_EN
               if (fail_inc == FAIL_SAT) begin
                  st_d       = C_LOCKED;
                  locked_d   = 1'b1;
                  lock_cnt_d = '0;
               end
`endif
            end
         end
         C_GRANT: if (bus.log_out) begin
            gled_d = 1'b0;
            rled_d = 1'b1;
            disp_d = '1;
            buf_d  = '0;
            idx_d  = '0;
            st_d   = C_ENTER;
         end
`ifdef ACCESS_LOCKOUT_EN
         C_LOCKED: begin
            if (lock_cnt_q == LOCK_LAST) begin
               locked_d = 1'b0;
               fail_d   = '0;
               st_d     = C_ENTER;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
`endif
         default: begin
            // corrupted encoding: fall back to the reset image
            st_d    = C_ENTER;
            idx_d   = '0;
            user_d  = '0;
            buf_d   = '0;
            disp_d  = '1;
            gled_d  = 1'b0;
            rled_d  = 1'b1;
            fail_d  = '0;
            match_d = 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            locked_d   = 1'b0;
            lock_cnt_d = '0;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= C_ENTER;
         idx_q   <= '0;
         user_q  <= '0;
         buf_q   <= '0;
         disp_q  <= '1;
         gled_q  <= 1'b0;
         rled_q  <= 1'b1;
         fail_q  <= '0;
         match_q <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
         locked_q   <= 1'b0;
         lock_cnt_q <= '0;
`endif
      end else begin
         st_q    <= st_d;
         idx_q   <= idx_d;
         user_q  <= user_d;
         buf_q   <= buf_d;
         disp_q  <= disp_d;
         gled_q  <= gled_d;
         rled_q  <= rled_d;
         fail_q  <= fail_d;
         match_q <= match_d;
`ifdef ACCESS_LOCKOUT_EN
         locked_q   <= locked_d;
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   assign bus.gled     = gled_q;
   assign bus.rled     = rled_q;
   assign bus.pwd_disp = disp_q;
   assign bus.fail_cnt = fail_q;
endmodule

// File: tb/tb_access_controller_p.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_access_controller_p;
   import access_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   access_controller_p_if #(.DIGIT_W(4), .NUM_DIGITS(4), .NUM_USERS(4), .MAX_FAIL(3)) b0 ();
   access_controller_p_if #(.DIGIT_W(8), .NUM_DIGITS(6), .NUM_USERS(4), .MAX_FAIL(3)) b1 ();

   access_controller_p #(.DIGIT_W(4), .NUM_DIGITS(4), .NUM_USERS(4), .ROM_LAT(2),
                         .MAX_FAIL(3), .LOCK_CYCLES(16))
      dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
   access_controller_p #(.DIGIT_W(8), .NUM_DIGITS(6), .NUM_USERS(4), .ROM_LAT(3),
                         .MAX_FAIL(3), .LOCK_CYCLES(16))
      dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

   // behavioural synchronous ROMs with ROM_LAT output stages
   logic [3:0] rom0 [16];
   logic [3:0] p0   [2];
   logic [7:0] rom1 [32];
   logic [7:0] p1   [3];
   always @(posedge clk) begin
      p0[0] <= rom0[b0.rom_addr];
      p0[1] <= p0[0];
      p1[0] <= rom1[b1.rom_addr];
      p1[1] <= p1[0];
      p1[2] <= p1[1];
   end
   assign b0.rom_data = p0[1];
   assign b1.rom_data = p1[2];

   typedef enum {K_GLED, K_RLED, K_FAIL, K_LOCK, K_DISP, K_ADDR} kind_e;
   typedef struct {
      int    due;
      int    dut;
      kind_e k;
      int    exp;
      string nm;
   } exp_t;

   exp_t sbq[$];
   int   n_run  = 0;
   int   n_fail = 0;
   int   pw[6];

   function automatic void expect_at(input int due, input int dut, input kind_e k,
                                     input int v, input string nm);
      exp_t e;
      int   i;
      e.due = due; e.dut = dut; e.k = k; e.exp = v; e.nm = nm;
      i = sbq.size();
      while (i > 0 && sbq[i-1].due > due) i--;
      sbq.insert(i, e);
   endfunction

   function automatic int sample(input int dut, input kind_e k);
      if (dut == 0) begin
         case (k)
            K_GLED: return int'(b0.gled);
            K_RLED: return int'(b0.rled);
            K_FAIL: return int'(b0.fail_cnt);
            K_LOCK: return int'(b0.locked);
            K_DISP: return int'(b0.pwd_disp);
            default: return int'(b0.rom_addr);
         endcase
      end
      case (k)
         K_GLED: return int'(b1.gled);
         K_RLED: return int'(b1.rled);
         K_FAIL: return int'(b1.fail_cnt);
         K_LOCK: return int'(b1.locked);
         K_DISP: return int'(b1.pwd_disp);
         default: return int'(b1.rom_addr);
      endcase
   endfunction

   // monitor
   initial begin
      exp_t e;
      int   act;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e   = sbq.pop_front();
            act = sample(e.dut, e.k);
            n_run++;
            if (e.due < cyc) begin
               n_fail++;
               $display("FAIL %s dut%0d: check due at cycle %0d missed (now %0d)", e.nm, e.dut, e.due, cyc);
            end else if (act != e.exp) begin
               n_fail++;
               $display("FAIL %s dut%0d @%0d: got %0d, expected %0d", e.nm, e.dut, cyc, act, e.exp);
            end
         end
      end
   end

   task automatic drv(input int dut, input bit ld, input int pass, input int user, input bit lo);
      if (dut == 0) begin
         b0.load_pass_number = ld; b0.pass_inp = 4'(pass); b0.user_sel = 2'(user); b0.log_out = lo;
      end else begin
         b1.load_pass_number = ld; b1.pass_inp = 8'(pass); b1.user_sel = 2'(user); b1.log_out = lo;
      end
   endtask

   // strobe held high for n consecutive cycles; e0 = cycle stamp of the last accepting edge
   task automatic enter(input int dut, input int user, input int n, output int e0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drv(dut, 1'b1, pw[i], user, 1'b0);
      end
      e0 = cyc + 1;
      @(negedge clk);
      drv(dut, 1'b0, 0, user, 1'b0);
   endtask

   task automatic run_entry(input int dut, input int user, input int n, input bit grant,
                            input int fail_e, input int lock_e, output int e0);
      int rl;
      int lat;
      rl  = (dut == 0) ? 2 : 3;
      lat = n * (rl + 2) + 1;
      enter(dut, user, n, e0);
      expect_at(e0 + 1, dut, K_DISP, pw[n-1], "disp_last_digit");
      for (int k = 0; k < n; k++)
         expect_at(e0 + 1 + k * (rl + 2), dut, K_ADDR, user * n + k, "rom_addr_seq");
      expect_at(e0 + lat - 1, dut, K_GLED, 0, "gled_before_latency");
      expect_at(e0 + lat, dut, K_GLED, int'(grant), "gled_decide");
      expect_at(e0 + lat, dut, K_RLED, int'(!grant), "rled_decide");
      expect_at(e0 + lat, dut, K_FAIL, fail_e, "fail_cnt_decide");
      expect_at(e0 + lat, dut, K_LOCK, lock_e, "locked_decide");
      repeat (lat + 1) @(negedge clk);
   endtask

   task automatic logout(input int dut);
      @(negedge clk);
      drv(dut, 1'b0, 0, 0, 1'b1);
      expect_at(cyc + 1, dut, K_GLED, 0, "logout_gled");
      expect_at(cyc + 1, dut, K_RLED, 1, "logout_rled");
      expect_at(cyc + 1, dut, K_DISP, (dut == 0) ? 15 : 255, "logout_disp");
      expect_at(cyc + 1, dut, K_ADDR, 0, "logout_addr");
      @(negedge clk);
      drv(dut, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic expect_reset(input int due);
      expect_at(due, 0, K_GLED, 0, "rst_gled");
      expect_at(due, 0, K_RLED, 1, "rst_rled");
      expect_at(due, 0, K_DISP, 15, "rst_disp");
      expect_at(due, 0, K_ADDR, 0, "rst_addr");
      expect_at(due, 0, K_FAIL, 0, "rst_fail");
      expect_at(due, 0, K_LOCK, 0, "rst_locked");
   endtask

   initial begin
      exp_t e;
      int   e0;
      int   d;
      for (int i = 0; i < 16; i++) rom0[i] = 4'(i);
      for (int i = 0; i < 32; i++) rom1[i] = 8'(i);
      rom0[0] = 4'd3; rom0[1]  = 4'd1; rom0[2]  = 4'd4; rom0[3]  = 4'd1;
      rom0[4] = 4'd5; rom0[5]  = 4'd5; rom0[6]  = 4'd5; rom0[7]  = 4'd5;
      rom0[8] = 4'd9; rom0[9]  = 4'd9; rom0[10] = 4'd0; rom0[11] = 4'd7;
      rom1[18] = 8'hA5; rom1[19] = 8'h3C; rom1[20] = 8'h00;
      rom1[21] = 8'hFF; rom1[22] = 8'h12; rom1[23] = 8'h7E;
      drv(0, 1'b0, 0, 0, 1'b0);
      drv(1, 1'b0, 0, 0, 1'b0);

      repeat (3) @(negedge clk);
      expect_reset(cyc + 1);
      expect_at(cyc + 1, 1, K_GLED, 0, "rst_gled_w");
      expect_at(cyc + 1, 1, K_DISP, 255, "rst_disp_w");
      rst = 1'b0;

      // correct password, then a stray strobe in GRANT, then logout
      pw = '{3, 1, 4, 1, 0, 0};
      run_entry(0, 0, 4, 1'b1, 0, 0, e0);
      drv(0, 1'b1, 7, 0, 1'b0);
      expect_at(cyc + 2, 0, K_DISP, 1, "grant_ignores_strobe");
      @(negedge clk);
      drv(0, 1'b0, 0, 0, 1'b0);
      logout(0);

      // wrong last digit, then the right one clears the failure count
      pw = '{3, 1, 4, 2, 0, 0};
      run_entry(0, 0, 4, 1'b0, 1, 0, e0);
      pw = '{3, 1, 4, 1, 0, 0};
      run_entry(0, 0, 4, 1'b1, 0, 0, e0);
      logout(0);

      // user select
      pw = '{9, 9, 0, 7, 0, 0};
      run_entry(0, 2, 4, 1'b1, 0, 0, e0);
      logout(0);
      run_entry(0, 1, 4, 1'b0, 1, 0, e0);

      // reset while the fetch sits in WAIT
      pw = '{9, 9, 0, 8, 0, 0};
      enter(0, 2, 4, e0);
      expect_at(e0 + 1, 0, K_ADDR, 8, "addr_before_rst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      expect_reset(cyc + 1);
      @(negedge clk);
      rst = 1'b0;
      expect_at(e0 + 17, 0, K_GLED, 0, "no_grant_after_rst");
      expect_at(e0 + 17, 0, K_FAIL, 0, "no_decide_after_rst");
      repeat (18) @(negedge clk);

      // repeated failures
      pw = '{3, 1, 4, 2, 0, 0};
      run_entry(0, 0, 4, 1'b0, 1, 0, e0);
      run_entry(0, 0, 4, 1'b0, 2, 0, e0);
`ifdef ACCESS_LOCKOUT_EN
      run_entry(0, 0, 4, 1'b0, 3, 1, e0);
      d = e0 + 17;
      expect_at(d + 15, 0, K_LOCK, 1, "locked_held");
      expect_at(d + 16, 0, K_LOCK, 0, "locked_expired");
      expect_at(d + 16, 0, K_FAIL, 0, "fail_cleared_unlock");
      expect_at(d + 16, 0, K_DISP, 2, "locked_ignores_strobe");
      @(negedge clk);
      pw = '{5, 5, 5, 5, 0, 0};
      enter(0, 1, 4, e0);
      repeat (12) @(negedge clk);
`else
      run_entry(0, 0, 4, 1'b0, 3, 0, e0);
      run_entry(0, 0, 4, 1'b0, 3, 0, e0);
      d = 0;
`endif
      pw = '{3, 1, 4, 1, 0, 0};
      run_entry(0, 0, 4, 1'b1, 0, 0, e0);
      logout(0);

      // wide configuration: 6 digits of 8 bits, ROM latency 3
      pw = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h12, 8'h7E};
      run_entry(1, 3, 6, 1'b1, 0, 0, e0);
      logout(1);
      pw = '{8'hA4, 8'h3C, 8'h00, 8'hFF, 8'h12, 8'h7E};
      run_entry(1, 3, 6, 1'b0, 1, 0, e0);

      for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_run++;
         n_fail++;
         $display("FAIL %s dut%0d: never checked (due %0d)", e.nm, e.dut, e.due);
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
